fas_peak_detect: RTL and testbench

- Spectrum-analysis stage of the frequency-analysis system; sits after the FFT stage.
- Consumes one complete FFT frame of N_BINS complex bins and scans it one bin per cycle, computing re²+im².
- Reports the index of the largest-magnitude bin (freq), its magnitude and a one-cycle done pulse.
- Generalised over bin count, sample width and DC-bin exclusion; adds busy/overrun flow reporting.

---
 rtl/fas_pkg.sv | 22 ++
 rtl/fas_cmag.sv | 27 ++
 rtl/fas_peak_detect.sv | 130 +++++++++++++
 tb/tb_fas_peak_detect.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared types and helpers for the frequency-analysis system stages.
`timescale 1ns/1ps
package fas_pkg;

  localparam int FAS_N_BINS = 16;
  localparam int FAS_DW     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } fas_state_t;

  function automatic int fas_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Sum of two signed squares needs twice the component width.
  function automatic int fas_mag_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/fas_cmag.sv
// Combinational squared magnitude re^2 + im^2 of one signed complex bin.
`timescale 1ns/1ps
module fas_cmag
  import fas_pkg::*;
#(
  parameter int DW    = FAS_DW,
  parameter int MAG_W = fas_mag_w(DW)
) (
  input  logic signed [DW-1:0]    re,
  input  logic signed [DW-1:0]    im,
  output logic        [MAG_W-1:0] mag
);

  logic signed [MAG_W-1:0] re_x;
  logic signed [MAG_W-1:0] im_x;
  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;

  assign re_x  = {{(MAG_W-DW){re[DW-1]}}, re};
  assign im_x  = {{(MAG_W-DW){im[DW-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  // Each square is non-negative and below 2^(MAG_W-1), so the unsigned sum cannot wrap.
  assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_peak_detect.sv
// Scans a captured FFT frame one bin per cycle and reports the largest-magnitude bin.
//   state | meaning
//   IDLE  | waiting for fft_valid; a frame seen here is captured
//   SCAN  | one bin compared per cycle; last bin publishes the result
`timescale 1ns/1ps
module fas_peak_detect
  import fas_pkg::*;
#(
  parameter int N_BINS  = FAS_N_BINS,
  parameter int DW      = FAS_DW,
  parameter int SKIP_DC = 0,
  parameter int IDX_W   = fas_clog2(N_BINS),
  parameter int MAG_W   = fas_mag_w(DW)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_valid,
  input  logic [N_BINS*2*DW-1:0]   fft_d,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         freq,
  output logic [MAG_W-1:0]         peak_mag,
  output logic                     overrun
);

  localparam int              FW    = N_BINS * 2 * DW;
  localparam logic [IDX_W-1:0] START = IDX_W'((SKIP_DC != 0) ? 1 : 0);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_BINS - 1);

  fas_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [MAG_W-1:0]  best_q, best_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [IDX_W-1:0]  freq_q, freq_d;
  logic [MAG_W-1:0]  peak_q, peak_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic [2*DW-1:0]   bin;
  logic [MAG_W-1:0]  mag;
  logic              take;
  logic [MAG_W-1:0]  cand_mag;
  logic [IDX_W-1:0]  cand_idx;

  always_comb begin
    bin = '0;
    for (int k = 0; k < N_BINS; k++) begin
      if (idx_q == IDX_W'(k)) bin = frame_q[k*2*DW +: 2*DW];
    end
  end

  fas_cmag #(.DW(DW), .MAG_W(MAG_W)) u_cmag (
    .re  ($signed(bin[2*DW-1:DW])),
    .im  ($signed(bin[DW-1:0])),
    .mag (mag)
  );

  // Strict compare keeps the earliest bin on ties.
  assign take     = (mag > best_q);
  assign cand_mag = take ? mag : best_q;
  assign cand_idx = take ? idx_q : best_idx_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    frame_d    = frame_q;
    freq_d     = freq_q;
    peak_d     = peak_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          frame_d    = fft_d;
          idx_d      = START;
          best_d     = '0;
          best_idx_d = START;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_d     = cand_mag;
        best_idx_d = cand_idx;
        idx_d      = idx_q + IDX_W'(1);
        if (fft_valid) overrun_d = 1'b1;
        if (idx_q == LAST) begin
          freq_d  = cand_idx;
          peak_d  = cand_mag;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      frame_q    <= '0;
      freq_q     <= '0;
      peak_q     <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      frame_q    <= frame_d;
      freq_q     <= freq_d;
      peak_q     <= peak_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy     = (state_q == SCAN);
  assign done     = done_q;
  assign freq     = freq_q;
  assign peak_mag = peak_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fas_peak_detect.sv
// Self-checking bench for fas_peak_detect: directed table, corner sequences, random frames.
`timescale 1ns/1ps
module tb_fas_peak_detect;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int FW = N * 2 * DW;

  typedef logic [FW-1:0] frame_t;

  typedef struct {
    string  name;
    int     sel;
    frame_t f;
    int     exp_freq;
    longint exp_mag;
    int     exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  frame_t      fft_d = '0;
  logic        busy0, done0, ovr0, busy1, done1, ovr1;
  logic [3:0]  freq0, freq1;
  logic [31:0] mag0, mag1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fas_peak_detect #(.N_BINS(N), .DW(DW), .SKIP_DC(0)) u_dut0 (
    .clk(clk), .rst(rst), .fft_valid(valid0), .fft_d(fft_d),
    .busy(busy0), .done(done0), .freq(freq0), .peak_mag(mag0), .overrun(ovr0)
  );

  fas_peak_detect #(.N_BINS(N), .DW(DW), .SKIP_DC(1)) u_dut1 (
    .clk(clk), .rst(rst), .fft_valid(valid1), .fft_d(fft_d),
    .busy(busy1), .done(done1), .freq(freq1), .peak_mag(mag1), .overrun(ovr1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t put(input frame_t f, input int k, input int re, input int im);
    logic [15:0] r, i;
    r = re[15:0];
    i = im[15:0];
    f[k*32 +: 32] = {r, i};
    return f;
  endfunction

  function automatic frame_t fill(input int re, input int im);
    frame_t f = '0;
    for (int k = 0; k < N; k++) f = put(f, k, re, im);
    return f;
  endfunction

  // Reference: plain arithmetic argmax over the searched bins, first maximum wins.
  function automatic void model(input frame_t f, input int skip, output int fq, output longint mg);
    longint re, im, m;
    fq = skip;
    mg = 0;
    for (int k = skip; k < N; k++) begin
      re = $signed(f[k*32+16 +: 16]);
      im = $signed(f[k*32 +: 16]);
      m  = re*re + im*im;
      if (m > mg) begin
        mg = m;
        fq = k;
      end
    end
  endfunction

  function automatic logic o_done(input int sel);  return sel != 0 ? done1 : done0; endfunction
  function automatic logic o_busy(input int sel);  return sel != 0 ? busy1 : busy0; endfunction
  function automatic logic o_ovr(input int sel);   return sel != 0 ? ovr1  : ovr0;  endfunction
  function automatic longint o_freq(input int sel); return sel != 0 ? longint'(freq1) : longint'(freq0); endfunction
  function automatic longint o_mag(input int sel);  return sel != 0 ? longint'(mag1)  : longint'(mag0);  endfunction

  task automatic start_frame(input int sel, input frame_t f);
    fft_d = f;
    if (sel != 0) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = o_busy(sel) ? 1 : 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (o_done(sel)) begin
        lat = c;
        break;
      end
      if (o_busy(sel)) busy_cnt++;
    end
  endtask

  task automatic run_check(input string tag, input int sel, input frame_t f,
                           input int ef, input longint em, input int elat);
    int lat, bc;
    start_frame(sel, f);
    wait_done(sel, lat, bc);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, bc, elat);
    check({tag, "_busy_in_done"}, longint'(o_busy(sel)), 0);
    check({tag, "_freq"}, o_freq(sel), ef);
    check({tag, "_mag"}, o_mag(sel), em);
  endtask

  vec_t vecs[6];

  initial begin
    frame_t tone, tie, ext, dc, zero;
    int lat, bc, pulses, ef, sel;
    longint em;

    tone = put('0, 5, 100, 0);
    tie  = put(put(fill(1, 1), 3, 3, 4), 9, 3, 4);
    ext  = put(put('0, 12, -32768, -32768), 2, 32767, 32767);
    dc   = put(put('0, 0, 1000, 0), 7, 0, -20);
    zero = '0;

    vecs[0] = '{"tone",     0, tone, 5,  64'd10000,      16};
    vecs[1] = '{"tie",      0, tie,  3,  64'd25,         16};
    vecs[2] = '{"extreme",  0, ext,  12, 64'd2147483648, 16};
    vecs[3] = '{"dc_skip",  1, dc,   7,  64'd400,        15};
    vecs[4] = '{"dc_keep",  0, dc,   0,  64'd1000000,    16};
    vecs[5] = '{"zero_skip",1, zero, 1,  64'd0,          15};

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d_busy", s), longint'(o_busy(s)), 0);
      check($sformatf("rst%0d_done", s), longint'(o_done(s)), 0);
      check($sformatf("rst%0d_freq", s), o_freq(s), 0);
      check($sformatf("rst%0d_mag", s),  o_mag(s), 0);
      check($sformatf("rst%0d_ovr", s),  longint'(o_ovr(s)), 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_check(vecs[i].name, vecs[i].sel, vecs[i].f, vecs[i].exp_freq, vecs[i].exp_mag, vecs[i].exp_lat);

    // Back-to-back: next frame accepted in the done cycle.
    start_frame(0, tone);
    wait_done(0, lat, bc);
    check("b2b_first_freq", o_freq(0), 5);
    start_frame(0, tie);
    wait_done(0, lat, bc);
    check("b2b_second_latency", lat, 16);
    check("b2b_second_freq", o_freq(0), 3);
    check("b2b_second_mag", o_mag(0), 25);
    check("b2b_ovr", longint'(o_ovr(0)), 0);

    // Overrun: a frame arriving mid-scan is dropped.
    start_frame(0, tone);
    repeat (3) begin @(posedge clk); #1; end
    start_frame(0, ext);
    wait_done(0, lat, bc);
    check("ovr_latency", lat, 12);
    check("ovr_freq", o_freq(0), 5);
    check("ovr_mag", o_mag(0), 10000);
    check("ovr_flag", longint'(o_ovr(0)), 1);
    check("ovr_other_dut", longint'(o_ovr(1)), 0);
    start_frame(0, tie);
    wait_done(0, lat, bc);
    check("ovr_sticky", longint'(o_ovr(0)), 1);

    // Reset mid-scan aborts without a done pulse.
    start_frame(0, ext);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", longint'(busy0), 0);
    check("mid_rst_done", longint'(done0), 0);
    check("mid_rst_freq", o_freq(0), 0);
    check("mid_rst_mag", o_mag(0), 0);
    check("mid_rst_ovr", longint'(ovr0), 0);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done0 || busy0) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    run_check("post_rst", 0, dc, 0, 1000000, 16);

    // Random frames against the reference model.
    for (int t = 0; t < 40; t++) begin
      frame_t f;
      int mode;
      sel  = t % 2;
      mode = $urandom_range(0, 2);
      f = '0;
      for (int k = 0; k < N; k++) begin
        if (mode == 0)
          f = put(f, k, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        else if (mode == 1)
          f = put(f, k, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
        else if ($urandom_range(0, 3) == 0)
          f = put(f, k, int'($urandom_range(0, 400)) - 200, 0);
      end
      model(f, sel, ef, em);
      run_check($sformatf("rand%0d", t), sel, f, ef, em, N - sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
